// File: rtl/switch_updown_counter.sv
`default_nettype none
// switch_updown_counter: synchronised, debounced board switches driving a prescaled
// up/down counter that wraps or saturates at MAX_VALUE.  Rev 1.0
module switch_updown_counter #(
  parameter int WIDTH          = 4,
  parameter int MAX_VALUE      = 2**WIDTH-1,
  parameter int TICK_PERIOD    = 12_500_000,
  parameter int DEBOUNCE_LIMIT = 250_000,
  parameter int SATURATE       = 0
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Enable,
  input  logic             i_Dir,
  input  logic             i_Clear,
  input  logic             i_Step,
  output logic [WIDTH-1:0] o_Count,
  output logic             o_Tick,
  output logic             o_Wrap
);

  localparam int PW = $clog2(TICK_PERIOD);
  localparam int DW = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [WIDTH-1:0] MAX_CNT    = WIDTH'(MAX_VALUE);
  localparam logic [PW-1:0]    LAST_PHASE = PW'(TICK_PERIOD - 1);

  // bit order: 0 enable, 1 dir, 2 clear, 3 step
  logic [3:0] raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] filt;

  assign raw = {i_Step, i_Clear, i_Dir, i_Enable};

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  generate
    if (DEBOUNCE_LIMIT == 0) begin : g_bypass
      assign filt = sync2;
    end else begin : g_debounce
      for (genvar i = 0; i < 4; i++) begin : g_chan
        logic [DW-1:0] stable_cnt;
        logic          filt_q;

        // Filtered value follows only after DEBOUNCE_LIMIT consecutive mismatching cycles.
        always_ff @(posedge i_Clk) begin
          if (!i_Rst_L) begin
            stable_cnt <= '0;
            filt_q     <= 1'b0;
          end else if (sync2[i] == filt_q) begin
            stable_cnt <= '0;
          end else if (stable_cnt == DW'(DEBOUNCE_LIMIT - 1)) begin
            stable_cnt <= '0;
            filt_q     <= sync2[i];
          end else begin
            stable_cnt <= stable_cnt + 1'b1;
          end
        end

        assign filt[i] = filt_q;
      end
    end
  endgenerate

  logic          enable_f;
  logic          dir_f;
  logic          clear_f;
  logic          step_f;
  logic          step_prev;
  logic [PW-1:0] phase;
  logic          tick_due;
  logic          step_hit;

  assign enable_f = filt[0];
  assign dir_f    = filt[1];
  assign clear_f  = filt[2];
  assign step_f   = filt[3];

  assign tick_due = enable_f && (phase == LAST_PHASE);
  assign step_hit = step_f && !step_prev && !enable_f;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      phase     <= '0;
      step_prev <= 1'b0;
      o_Count   <= '0;
      o_Tick    <= 1'b0;
      o_Wrap    <= 1'b0;
    end else begin
      step_prev <= step_f;
      o_Tick    <= 1'b0;
      o_Wrap    <= 1'b0;
      if (clear_f) begin
        phase   <= '0;
        o_Count <= '0;
      end else begin
        // Prescaler only moves while running so a pause keeps its phase.
        if (enable_f) begin
          phase <= tick_due ? '0 : phase + 1'b1;
        end
        if (tick_due || step_hit) begin
          o_Tick <= 1'b1;
          if (!dir_f) begin
            if (o_Count < MAX_CNT) begin
              o_Count <= o_Count + 1'b1;
            end else if (SATURATE == 0) begin
              o_Count <= '0;
              o_Wrap  <= 1'b1;
            end
          end else begin
            if (o_Count != '0) begin
              o_Count <= o_Count - 1'b1;
            end else if (SATURATE == 0) begin
              o_Count <= MAX_CNT;
              o_Wrap  <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_switch_updown_counter.sv
`default_nettype none
// tb_switch_updown_counter: directed vector table plus randomized run checked
// against a behavioural model, for a wrapping and a saturating instance.
module tb_switch_updown_counter;

  localparam int MAXV = 9;
  localparam int TP   = 10;
  localparam int DL   = 3;

  logic       clk = 1'b0;
  logic       rst_n, en, dir, clr, stp;
  logic [3:0] cnt_w, cnt_s;
  logic       tick_w, wrap_w, tick_s, wrap_s;

  always #5 clk = ~clk;

  switch_updown_counter #(.WIDTH(4), .MAX_VALUE(MAXV), .TICK_PERIOD(TP),
                          .DEBOUNCE_LIMIT(DL), .SATURATE(0)) dut_wrap (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en), .i_Dir(dir), .i_Clear(clr),
    .i_Step(stp), .o_Count(cnt_w), .o_Tick(tick_w), .o_Wrap(wrap_w));

  switch_updown_counter #(.WIDTH(4), .MAX_VALUE(MAXV), .TICK_PERIOD(TP),
                          .DEBOUNCE_LIMIT(DL), .SATURATE(1)) dut_sat (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en), .i_Dir(dir), .i_Clear(clr),
    .i_Step(stp), .o_Count(cnt_s), .o_Tick(tick_s), .o_Wrap(wrap_s));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: raw -> 2-cycle delay -> "must differ DL cycles in a row"
  // filter; counter arithmetic done on plain integers modulo MAXV+1.
  int ms1[4], ms2[4], mf[4], mrun[4];
  int mphase, mprev;
  int mcnt[2], mtick[2], mwrap[2];

  task automatic model_step();
    int  raw[4];
    int  nxt;
    bit  due, hit;
    bit  f_en, f_dir, f_clr, f_stp;
    raw[0] = int'(en); raw[1] = int'(dir); raw[2] = int'(clr); raw[3] = int'(stp);
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        ms1[i] = 0; ms2[i] = 0; mf[i] = 0; mrun[i] = 0;
      end
      mphase = 0; mprev = 0;
      for (int k = 0; k < 2; k++) begin
        mcnt[k] = 0; mtick[k] = 0; mwrap[k] = 0;
      end
    end else begin
      f_en  = (mf[0] != 0);
      f_dir = (mf[1] != 0);
      f_clr = (mf[2] != 0);
      f_stp = (mf[3] != 0);
      due = f_en && (mphase == TP - 1);
      hit = f_stp && (mprev == 0) && !f_en;
      for (int i = 0; i < 4; i++) begin
        if (ms2[i] != mf[i]) begin
          mrun[i]++;
          if (mrun[i] >= DL) begin
            mf[i]   = ms2[i];
            mrun[i] = 0;
          end
        end else begin
          mrun[i] = 0;
        end
        ms2[i] = ms1[i];
        ms1[i] = raw[i];
      end
      mprev = int'(f_stp);
      for (int k = 0; k < 2; k++) begin
        mtick[k] = 0; mwrap[k] = 0;
      end
      if (f_clr) begin
        mphase = 0;
        mcnt[0] = 0; mcnt[1] = 0;
      end else begin
        if (f_en) mphase = (mphase + 1) % TP;
        if (due || hit) begin
          for (int k = 0; k < 2; k++) begin
            nxt = mcnt[k] + (f_dir ? -1 : 1);
            mtick[k] = 1;
            if (nxt < 0 || nxt > MAXV) begin
              if (k == 0) begin
                nxt      = (nxt + MAXV + 1) % (MAXV + 1);
                mwrap[k] = 1;
              end else begin
                nxt = mcnt[k];
              end
            end
            mcnt[k] = nxt;
          end
        end
      end
    end
  endtask

  int tk_acc, wr_acc, stk_acc, swr_acc;
  bit cmp_model = 1'b0;

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    tk_acc  += int'(tick_w);
    wr_acc  += int'(wrap_w);
    stk_acc += int'(tick_s);
    swr_acc += int'(wrap_s);
    if (cmp_model) begin
      check("model_count_wrapinst", int'(cnt_w), mcnt[0]);
      check("model_tick_wrapinst",  int'(tick_w), mtick[0]);
      check("model_wrap_wrapinst",  int'(wrap_w), mwrap[0]);
      check("model_count_satinst",  int'(cnt_s), mcnt[1]);
      check("model_tick_satinst",   int'(tick_s), mtick[1]);
      check("model_wrap_satinst",   int'(wrap_s), mwrap[1]);
    end
  endtask

  typedef struct {
    bit r, e, d, c, s;
    int cyc;
    int m_cnt, m_tk, m_wr;
    bit s_chk;
    int s_cnt, s_tk, s_wr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit e, bit d, bit c, bit s, int cyc,
                              int mc, int mt, int mw,
                              bit sc = 1'b0, int scn = 0, int st = 0, int sw = 0);
    vec_t v;
    v.r = r; v.e = e; v.d = d; v.c = c; v.s = s; v.cyc = cyc;
    v.m_cnt = mc; v.m_tk = mt; v.m_wr = mw;
    v.s_chk = sc; v.s_cnt = scn; v.s_tk = st; v.s_wr = sw;
    tbl.push_back(v);
  endfunction

  initial begin
    // reset with all inputs high
    add(0,1,1,1,1, 5, 0,0,0, 1,0,0,0);
    // run up: first update 15 edges after release, then every 10
    add(1,1,0,0,0, 14, 0,0,0);
    add(1,1,0,0,0,  1, 1,1,0);
    add(1,1,0,0,0, 80, 9,8,0);
    add(1,1,0,0,0,  9, 9,0,0);
    add(1,1,0,0,0,  1, 0,1,1);
    add(1,1,0,0,0,  1, 0,0,0);
    // down from 0 wraps to 9, then count down to 6
    add(1,1,1,0,0,  9, 9,1,1);
    add(1,1,1,0,0, 30, 6,3,0);
    // reset mid-count, then restart running down
    add(0,1,1,0,0,  1, 0,0,0);
    add(1,1,1,0,0, 15, 9,1,1);
    add(1,1,1,0,0, 50, 4,5,0);
    // pause at 4, three clean step presses counting up
    add(1,0,0,0,0, 50, 4,0,0);
    add(1,0,0,0,1,  8, 5,1,0);
    add(1,0,0,0,0,  8, 5,0,0);
    add(1,0,0,0,1,  8, 6,1,0);
    add(1,0,0,0,0,  8, 6,0,0);
    add(1,0,0,0,1,  8, 7,1,0);
    add(1,0,0,0,0,  8, 7,0,0);
    // re-enable with step held: tick after remaining phase only
    add(1,1,0,0,1,  9, 7,0,0);
    add(1,1,0,0,1,  1, 8,1,0);
    // 2-cycle enable glitch ignored, prescaler keeps running
    add(1,0,0,0,1,  2, 8,0,0);
    add(1,1,0,0,1,  8, 9,1,0);
    // pause, then a bouncing step followed by a stable press
    add(1,0,0,0,0, 20, 9,0,0);
    add(1,0,0,0,1,  1, 9,0,0);
    add(1,0,0,0,0,  1, 9,0,0);
    add(1,0,0,0,1,  1, 9,0,0);
    add(1,0,0,0,0,  1, 9,0,0);
    add(1,0,0,0,1,  1, 9,0,0);
    add(1,0,0,0,0,  1, 9,0,0);
    add(1,0,0,0,1, 10, 0,1,1);
    add(1,0,0,0,0,  8, 0,0,0);
    // clear lands on the edge a tick is due
    add(1,1,0,0,0, 24, 2,2,0);
    add(1,1,0,1,0,  5, 2,0,0);
    add(1,1,0,1,0,  1, 0,0,0);
    add(1,1,0,1,0, 10, 0,0,0);
    add(1,1,0,0,0, 14, 0,0,0);
    add(1,1,0,0,0,  1, 1,1,0);
    // saturating vs wrapping instance
    add(0,1,0,0,0,   2, 0,0,0,  1,0,0,0);
    add(1,1,0,0,0, 116, 1,11,1, 1,9,11,0);
    add(1,1,1,0,0, 104, 1,10,1, 1,0,10,0);

    for (int n = 0; n < tbl.size(); n++) begin
      rst_n = tbl[n].r; en = tbl[n].e; dir = tbl[n].d; clr = tbl[n].c; stp = tbl[n].s;
      tk_acc = 0; wr_acc = 0; stk_acc = 0; swr_acc = 0;
      repeat (tbl[n].cyc) cycle();
      check($sformatf("vec%0d_count", n), int'(cnt_w), tbl[n].m_cnt);
      check($sformatf("vec%0d_ticks", n), tk_acc, tbl[n].m_tk);
      check($sformatf("vec%0d_wraps", n), wr_acc, tbl[n].m_wr);
      if (tbl[n].s_chk) begin
        check($sformatf("vec%0d_sat_count", n), int'(cnt_s), tbl[n].s_cnt);
        check($sformatf("vec%0d_sat_ticks", n), stk_acc, tbl[n].s_tk);
        check($sformatf("vec%0d_sat_wraps", n), swr_acc, tbl[n].s_wr);
      end
    end

    // randomized segments compared every cycle against the model
    cmp_model = 1'b1;
    for (int seg = 0; seg < 220; seg++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      en    = ($urandom_range(0, 3) != 0);
      dir   = 1'($urandom_range(0, 1));
      clr   = ($urandom_range(0, 7) == 0);
      stp   = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 16)) cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
